bistable_event_capture: RTL and testbench

BISTABLE_EVENT_CAPTURE -- requirements
Module: bistable_event_capture

---
 rtl/bistable_event_capture.sv | 82 ++++++++
 tb/tb_bistable_event_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bistable_event_capture.sv
// Synchronizes and debounces a multi-bit level bus, updating the filtered copy as a whole word,
// and reports accepted edges as one-cycle pulses plus sticky, write-one-to-clear status with a masked interrupt.
module bistable_event_capture #(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] int_en,
    output logic [WIDTH-1:0] status,
    output logic             irq
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] status_q, status_d;

    // Candidate tracks the synchronized bus; the whole word is accepted only once it has been stable long enough.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if ((cnt_q == CNT_MAX) && (cand_q != level_q)) begin
            level_d = cand_q;
        end

        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;

        // Setting wins over clearing both on the update edge and while the pulse is visible.
        status_d = (status_q & ~clr) | rise_d | fall_d | rise_q | fall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
        end else begin
            sync1_q  <= in_async;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
        end
    end

    assign level_out = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign status    = status_q;
    assign irq       = |(status_q & int_en);

endmodule

// File: tb/tb_bistable_event_capture.sv
// Scoreboard bench for bistable_event_capture: expected output snapshots are queued per clock edge
// when stimulus is applied and compared at the following falling edges.
module tb_bistable_event_capture;

    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_async;
    logic [W-1:0] level_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] clr;
    logic [W-1:0] int_en;
    logic [W-1:0] status;
    logic         irq;

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;

    typedef struct {
        string        tag;
        int           cyc;
        logic [W-1:0] lvl;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        logic [W-1:0] st;
        logic         iq;
    } exp_t;

    exp_t sb_q[$];

    bistable_event_capture #(
        .WIDTH        (W),
        .STABLE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_async (in_async),
        .level_out(level_out),
        .rise     (rise),
        .fall     (fall),
        .clr      (clr),
        .int_en   (int_en),
        .status   (status),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the expected outputs as seen after edge (edge_cnt + off).
    task automatic expect_at(input string tag, input int off, input logic [W-1:0] lvl,
                             input logic [W-1:0] rs, input logic [W-1:0] fl,
                             input logic [W-1:0] st, input logic iq);
        exp_t e;
        e.tag = tag;
        e.cyc = edge_cnt + off;
        e.lvl = lvl;
        e.rs  = rs;
        e.fl  = fl;
        e.st  = st;
        e.iq  = iq;
        sb_q.push_back(e);
    endtask

    task automatic expect_quiet(input string tag, input int from, input int to,
                                input logic [W-1:0] lvl, input logic [W-1:0] st, input logic iq);
        for (int i = from; i <= to; i++) expect_at(tag, i, lvl, 2'b00, 2'b00, st, iq);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            e = sb_q.pop_front();
            if (e.cyc < edge_cnt) begin
                chk({e.tag, "_missed"}, 32'(e.cyc), 32'(edge_cnt));
            end else begin
                chk({e.tag, "_level"},  32'(level_out), 32'(e.lvl));
                chk({e.tag, "_rise"},   32'(rise),      32'(e.rs));
                chk({e.tag, "_fall"},   32'(fall),      32'(e.fl));
                chk({e.tag, "_status"}, 32'(status),    32'(e.st));
                chk({e.tag, "_irq"},    32'(irq),       32'(e.iq));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        rst      = 1'b0;
        in_async = 2'b11;
        clr      = 2'b11;
        int_en   = 2'b11;
        tick(3);
        chk("rst_level",  32'(level_out), 32'(0));
        chk("rst_status", 32'(status),    32'(0));
        chk("rst_irq",    32'(irq),       32'(0));

        // Idle after reset release.
        in_async = 2'b00;
        clr      = 2'b00;
        int_en   = 2'b01;
        rst      = 1'b1;
        expect_quiet("idle", 1, 6, 2'b00, 2'b00, 1'b0);
        tick(7);

        // 00 -> 11 accepted after four edges.
        in_async = 2'b11;
        expect_quiet("up_wait", 1, 4, 2'b00, 2'b00, 1'b0);
        expect_at("up_edge", 5, 2'b11, 2'b11, 2'b00, 2'b11, 1'b1);
        expect_at("up_post", 6, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        tick(7);

        // Interrupt masking does not touch status.
        int_en = 2'b00;
        expect_at("ien_off", 1, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0);
        tick(1);
        int_en = 2'b10;
        expect_at("ien_hi", 1, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        tick(1);
        int_en = 2'b01;
        tick(1);

        // One-cycle glitch is rejected.
        in_async = 2'b00;
        expect_quiet("glitch", 1, 8, 2'b11, 2'b11, 1'b1);
        tick(1);
        in_async = 2'b11;
        tick(8);

        // Write-one-to-clear on a single bit, then all bits.
        clr = 2'b01;
        expect_at("clr0", 1, 2'b11, 2'b00, 2'b00, 2'b10, 1'b0);
        tick(1);
        clr = 2'b00;
        tick(1);
        clr = 2'b11;
        expect_at("clr_all", 1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        clr = 2'b00;
        tick(1);

        // Fall on bit 1 while clr[1] is held: set wins.
        in_async = 2'b01;
        expect_quiet("fall1_wait", 1, 4, 2'b11, 2'b00, 1'b0);
        tick(4);
        clr = 2'b10;
        expect_at("fall1_edge", 1, 2'b01, 2'b00, 2'b10, 2'b10, 1'b0);
        expect_at("fall1_clr",  2, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
        tick(2);
        clr = 2'b00;
        expect_at("fall1_hold", 1, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
        tick(2);
        clr = 2'b11;
        expect_at("clr_all2", 1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        clr = 2'b00;
        tick(1);

        // Back to 00: fall on bit 0.
        in_async = 2'b00;
        expect_quiet("fall0_wait", 1, 4, 2'b01, 2'b00, 1'b0);
        expect_at("fall0_edge", 5, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
        expect_at("fall0_post", 6, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
        tick(7);
        clr = 2'b11;
        expect_at("clr_all3", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        clr = 2'b00;
        tick(1);

        // Skewed arrival: 01 then 11 one cycle later goes straight to 11.
        in_async = 2'b01;
        expect_quiet("skew_wait", 1, 5, 2'b00, 2'b00, 1'b0);
        expect_at("skew_edge", 6, 2'b11, 2'b11, 2'b00, 2'b11, 1'b1);
        expect_at("skew_post", 7, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        tick(1);
        in_async = 2'b11;
        tick(7);

        // Both bits fall together, status stays set.
        in_async = 2'b00;
        expect_quiet("dn_wait", 1, 4, 2'b11, 2'b11, 1'b1);
        expect_at("dn_edge", 5, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1);
        expect_at("dn_post", 6, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
        tick(7);

        // Reset mid-filtering with candidate 11 pending.
        in_async = 2'b11;
        tick(3);
        #1;
        rst    = 1'b0;
        int_en = 2'b11;
        clr    = 2'b11;
        #1;
        chk("arst_level",  32'(level_out), 32'(0));
        chk("arst_rise",   32'(rise),      32'(0));
        chk("arst_fall",   32'(fall),      32'(0));
        chk("arst_status", 32'(status),    32'(0));
        chk("arst_irq",    32'(irq),       32'(0));
        tick(1);
        int_en = 2'b01;
        clr    = 2'b00;
        rst    = 1'b1;
        expect_quiet("requal_wait", 1, 4, 2'b00, 2'b00, 1'b0);
        expect_at("requal_edge", 5, 2'b11, 2'b11, 2'b00, 2'b11, 1'b1);
        expect_at("requal_post", 6, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        tick(8);

        chk("sb_drain", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
